// File: rtl/spm_pkg.sv
// Shared OCP command/response codes, sweep FSM states and
// elaboration helpers for the byte-lane scratchpad bank.
package spm_pkg;

    localparam logic [2:0] OCP_CMD_IDLE = 3'b000;
    localparam logic [2:0] OCP_CMD_WR   = 3'b001;
    localparam logic [2:0] OCP_CMD_RD   = 3'b010;

    localparam logic [1:0] OCP_RESP_NULL = 2'b00;
    localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
    localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } spm_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spm_byte_lane.sv
// One 8-bit byte lane of the scratchpad: WORDS deep,
// synchronous write and registered synchronous read.
module spm_byte_lane #(
    parameter int WORDS = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/spm_ocp_bank.sv
// Byte-lane scratchpad behind an OCP-style port: in-order
// DVA/ERR responses, range check and a post-reset zero sweep.
module spm_ocp_bank
    import spm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE_BYTES     = 256,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              io_M_Cmd,
    input  logic [ADDR_WIDTH-1:0]   io_M_Addr,
    input  logic [DATA_WIDTH-1:0]   io_M_Data,
    input  logic [DATA_WIDTH/8-1:0] io_M_ByteEn,
    output logic                    io_S_CmdAccept,
    output logic [1:0]              io_S_Resp,
    output logic [DATA_WIDTH-1:0]   io_S_Data,
    output logic                    io_S_Busy
);

    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int WORDS      = SIZE_BYTES / BYTE_LANES;
    localparam int LANE_W     = clog2(BYTE_LANES);
    localparam int SIZE_W     = clog2(SIZE_BYTES);
    localparam int IDX_W      = (SIZE_W > LANE_W) ? SIZE_W - LANE_W : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(SIZE_BYTES);

    spm_state_e       state, state_next;
    logic [IDX_W-1:0] cnt, cnt_next;
    logic             clearing, ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clearing   = 1'b0;
        ready      = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                clearing = 1'b1;
                cnt_next = cnt + 1'b1;
                if (cnt == IDX_W'(WORDS - 1)) state_next = ST_READY;
            end
            ST_READY: ready = 1'b1;
        endcase
    end

    logic             is_wr, is_rd, accept, in_range;
    logic [IDX_W-1:0] idx, ram_addr;
    logic [DATA_WIDTH-1:0] ram_q;

    assign is_wr    = (io_M_Cmd == OCP_CMD_WR);
    assign is_rd    = (io_M_Cmd == OCP_CMD_RD);
    assign accept   = ready && (is_wr || is_rd);
    assign in_range = {1'b0, io_M_Addr} < LIMIT;
    assign idx      = IDX_W'(io_M_Addr >> LANE_W);
    assign ram_addr = clearing ? cnt : idx;

    for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
        logic       we;
        logic [7:0] wdata;
        assign we    = clearing || (accept && is_wr && in_range && io_M_ByteEn[i]);
        assign wdata = clearing ? 8'h00 : io_M_Data[8*i +: 8];

        spm_byte_lane #(
            .WORDS (WORDS),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk   (clk),
            .we    (we),
            .re    (accept && is_rd && in_range),
            .addr  (ram_addr),
            .wdata (wdata),
            .rdata (ram_q[8*i +: 8])
        );
    end

    // Stage 1 tracks the RAM read; read data is masked unless it is a DVA read.
    logic [1:0]            resp1;
    logic                  rd1;
    logic [DATA_WIDTH-1:0] data1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp1 <= OCP_RESP_NULL;
            rd1   <= 1'b0;
        end else begin
            resp1 <= !accept ? OCP_RESP_NULL :
                     in_range ? OCP_RESP_DVA : OCP_RESP_ERR;
            rd1   <= accept && is_rd && in_range;
        end
    end

    assign data1 = rd1 ? ram_q : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0]            resp2;
        logic [DATA_WIDTH-1:0] data2;
        always_ff @(posedge clk) begin
            if (!reset) begin
                resp2 <= OCP_RESP_NULL;
                data2 <= '0;
            end else begin
                resp2 <= resp1;
                data2 <= data1;
            end
        end
        assign io_S_Resp = resp2;
        assign io_S_Data = data2;
    end else begin : g_out_comb
        assign io_S_Resp = resp1;
        assign io_S_Data = data1;
    end

    assign io_S_CmdAccept = ready;
    assign io_S_Busy      = clearing;

endmodule

// File: tb/tb_spm_ocp_bank.sv
// Directed bench: default 32-bit bank plus a 64-bit, 128-byte
// bank with the extra response register stage.
module tb_spm_ocp_bank;
    import spm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  a_cmd;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    logic [3:0]  a_be;
    logic        a_acc, a_busy;
    logic [1:0]  a_resp;
    logic [31:0] a_rdata;

    logic [2:0]  b_cmd;
    logic [7:0]  b_addr;
    logic [63:0] b_data;
    logic [7:0]  b_be;
    logic        b_acc, b_busy;
    logic [1:0]  b_resp;
    logic [63:0] b_rdata;

    spm_ocp_bank u_a (
        .clk            (clk),
        .reset          (reset),
        .io_M_Cmd       (a_cmd),
        .io_M_Addr      (a_addr),
        .io_M_Data      (a_data),
        .io_M_ByteEn    (a_be),
        .io_S_CmdAccept (a_acc),
        .io_S_Resp      (a_resp),
        .io_S_Data      (a_rdata),
        .io_S_Busy      (a_busy)
    );

    spm_ocp_bank #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (64),
        .SIZE_BYTES     (128),
        .OUT_REG        (1),
        .CLEAR_ON_RESET (1)
    ) u_b (
        .clk            (clk),
        .reset          (reset),
        .io_M_Cmd       (b_cmd),
        .io_M_Addr      (b_addr),
        .io_M_Data      (b_data),
        .io_M_ByteEn    (b_be),
        .io_S_CmdAccept (b_acc),
        .io_S_Resp      (b_resp),
        .io_S_Data      (b_rdata),
        .io_S_Busy      (b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one command on bank A; L=1 so its response is visible next negedge.
    task automatic a_step(input logic [2:0] cmd, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic [1:0] er, input logic [31:0] ed,
                          input string tag);
        a_cmd  = cmd;
        a_addr = addr;
        a_data = data;
        a_be   = be;
        @(negedge clk);
        check({tag, " resp"}, 64'(a_resp), 64'(er));
        check({tag, " data"}, 64'(a_rdata), 64'(ed));
    endtask

    // Bank B has L=2: nothing after one cycle, the response after two.
    task automatic b_step(input logic [2:0] cmd, input logic [7:0] addr,
                          input logic [63:0] data, input logic [7:0] be,
                          input logic [1:0] er, input logic [63:0] ed,
                          input string tag);
        b_cmd  = cmd;
        b_addr = addr;
        b_data = data;
        b_be   = be;
        @(negedge clk);
        check({tag, " lat1"}, 64'(b_resp), 64'(OCP_RESP_NULL));
        b_cmd = OCP_CMD_IDLE;
        @(negedge clk);
        check({tag, " resp"}, 64'(b_resp), 64'(er));
        check({tag, " data"}, b_rdata, ed);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (a_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [31:0] model [64];
    int n;

    initial begin
        a_cmd = OCP_CMD_IDLE; a_addr = '0; a_data = '0; a_be = '0;
        b_cmd = OCP_CMD_IDLE; b_addr = '0; b_data = '0; b_be = '0;
        for (int i = 0; i < 64; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        check("rst accept", 64'(a_acc), 64'(0));
        check("rst busy", 64'(a_busy), 64'(1));
        check("rst resp", 64'(a_resp), 64'(OCP_RESP_NULL));
        check("rst data", 64'(a_rdata), 64'(0));
        check("rst b accept", 64'(b_acc), 64'(0));

        reset = 1'b1;
        count_busy(n);
        check("sweep cycles", 64'(n), 64'(64));
        check("ready accept", 64'(a_acc), 64'(1));
        check("ready busy", 64'(a_busy), 64'(0));
        check("b ready", 64'(b_acc), 64'(1));

        a_step(OCP_CMD_RD, 8'h10, 32'h0, 4'h0, OCP_RESP_DVA, 32'h0, "rd cleared");
        a_step(OCP_CMD_WR, 8'h04, 32'hDEADBEEF, 4'hF, OCP_RESP_DVA, 32'h0, "wr full");
        a_step(OCP_CMD_RD, 8'h04, 32'h0, 4'h0, OCP_RESP_DVA, 32'hDEADBEEF, "rd full");
        a_step(OCP_CMD_WR, 8'h04, 32'h11223344, 4'h5, OCP_RESP_DVA, 32'h0, "wr lanes");
        a_step(OCP_CMD_RD, 8'h04, 32'h0, 4'h0, OCP_RESP_DVA, 32'hDE22BE44, "rd lanes");
        a_step(OCP_CMD_IDLE, 8'h04, 32'h0, 4'hF, OCP_RESP_NULL, 32'h0, "idle");
        a_step(3'b111, 8'h04, 32'hFFFFFFFF, 4'hF, OCP_RESP_NULL, 32'h0, "bad cmd");
        a_step(OCP_CMD_RD, 8'h07, 32'h0, 4'h0, OCP_RESP_DVA, 32'hDE22BE44, "rd low bits");
        model[1] = 32'hDE22BE44;

        a_step(OCP_CMD_WR, 8'hFC, 32'hA5A5A5A5, 4'hF, OCP_RESP_DVA, 32'h0, "wr top");
        model[63] = 32'hA5A5A5A5;
        a_step(OCP_CMD_WR, 8'h08, 32'hCAFEF00D, 4'hF, OCP_RESP_DVA, 32'h0, "wr hazard");
        a_step(OCP_CMD_RD, 8'h08, 32'h0, 4'h0, OCP_RESP_DVA, 32'hCAFEF00D, "rd hazard");
        model[2] = 32'hCAFEF00D;
        for (int i = 0; i < 64; i++) begin
            a_step(OCP_CMD_RD, 8'(i * 4), 32'h0, 4'h0, OCP_RESP_DVA, model[i],
                   $sformatf("b2b rd %0d", i));
        end
        a_cmd = OCP_CMD_IDLE;

        b_step(OCP_CMD_WR, 8'h08, 64'h0123456789ABCDEF, 8'hF0,
               OCP_RESP_DVA, 64'h0, "b wr lanes");
        b_step(OCP_CMD_RD, 8'h08, 64'h0, 8'h00,
               OCP_RESP_DVA, 64'h0123456700000000, "b rd lanes");
        b_step(OCP_CMD_RD, 8'h80, 64'h0, 8'h00, OCP_RESP_ERR, 64'h0, "b rd oor");
        b_step(OCP_CMD_WR, 8'h88, 64'hFFFFFFFFFFFFFFFF, 8'hFF,
               OCP_RESP_ERR, 64'h0, "b wr oor");
        b_step(OCP_CMD_RD, 8'h88, 64'h0, 8'h00, OCP_RESP_ERR, 64'h0, "b rd oor alias");
        b_step(OCP_CMD_RD, 8'h08, 64'h0, 8'h00,
               OCP_RESP_DVA, 64'h0123456700000000, "b rd kept");
        b_step(OCP_CMD_RD, 8'h78, 64'h0, 8'h00, OCP_RESP_DVA, 64'h0, "b rd last");
        b_step(OCP_CMD_RD, 8'hFF, 64'h0, 8'h00, OCP_RESP_ERR, 64'h0, "b rd max");

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("mid sweep busy", 64'(a_busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("mid rst busy", 64'(a_busy), 64'(1));
        reset = 1'b1;
        count_busy(n);
        check("resweep cycles", 64'(n), 64'(64));
        a_step(OCP_CMD_RD, 8'h04, 32'h0, 4'h0, OCP_RESP_DVA, 32'h0, "rd recleared");
        a_cmd = OCP_CMD_IDLE;

        a_cmd = OCP_CMD_RD; a_addr = 8'h08;
        b_cmd = OCP_CMD_RD; b_addr = 8'h08;
        @(negedge clk);
        check("flight b lat1", 64'(b_resp), 64'(OCP_RESP_NULL));
        a_cmd = OCP_CMD_IDLE;
        b_cmd = OCP_CMD_IDLE;
        reset = 1'b0;
        @(negedge clk);
        check("flight a resp", 64'(a_resp), 64'(OCP_RESP_NULL));
        check("flight b resp", 64'(b_resp), 64'(OCP_RESP_NULL));
        check("flight b data", b_rdata, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        check("flight b after", 64'(b_resp), 64'(OCP_RESP_NULL));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
